sgpr_simxlsu_rd_port_arb: RTL and testbench

//  Read-side counterpart of the SGPR write-port mux. Arbitrates up to NUM_PORTS requesters (SALU, LSU, SIMD/SIMF

---
 rtl/sgpr_simxlsu_rd_port_arb_pkg.sv | 36 +++
 rtl/sgpr_rr_arbiter.sv | 42 ++++
 rtl/sgpr_simxlsu_rd_port_arb.sv | 75 +++++++
 tb/tb_sgpr_simxlsu_rd_port_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sgpr_simxlsu_rd_port_arb_pkg.sv
// Shared sizes, port ids and owner-pipeline types for the SGPR read-port arbiter.
// No logic; latency and backpressure are defined by the modules that import it.
package sgpr_simxlsu_rd_port_arb_pkg;

  localparam int SGPR_RD_PORTS = 10;
  localparam int SGPR_ADDR_W   = 9;
  localparam int SGPR_DATA_W   = 128;
  localparam int SGPR_RD_LAT   = 1;
  localparam int PORT_IDX_W    = 4;
  localparam int PORT_SEL_W    = 16;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef enum logic [PORT_IDX_W-1:0] {
    PORT_SIMD0 = 4'd0,
    PORT_SIMD1 = 4'd1,
    PORT_SIMD2 = 4'd2,
    PORT_SIMD3 = 4'd3,
    PORT_SIMF0 = 4'd4,
    PORT_SIMF1 = 4'd5,
    PORT_SIMF2 = 4'd6,
    PORT_SIMF3 = 4'd7,
    PORT_LSU   = 4'd8,
    PORT_SALU  = 4'd9
  } port_id_e;

  typedef struct packed {
    logic      vld;
    port_idx_t idx;
  } owner_t;

  function automatic logic [PORT_SEL_W-1:0] port_onehot(input port_idx_t idx);
    return PORT_SEL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/sgpr_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr (mod NUM_PORTS), plus the pointer to use next.
// Purely combinational; a port that is not picked simply keeps its request up.
module sgpr_rr_arbiter
  import sgpr_simxlsu_rd_port_arb_pkg::*;
#(
  parameter int NUM_PORTS = SGPR_RD_PORTS
) (
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 grant_vld,
  output port_idx_t            grant_idx,
  output port_idx_t            next_ptr
);

  logic [PORT_IDX_W:0] cand;
  port_idx_t           cand_idx;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    next_ptr  = ptr;
    cand      = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr} + (PORT_IDX_W+1)'(k);
      if (cand >= (PORT_IDX_W+1)'(NUM_PORTS))
        cand = cand - (PORT_IDX_W+1)'(NUM_PORTS);
      cand_idx = cand[PORT_IDX_W-1:0];
      if (!grant_vld && req[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
      next_ptr = (grant_idx == PORT_IDX_W'(NUM_PORTS-1)) ? '0 : grant_idx + PORT_IDX_W'(1);
    end
  end

endmodule

// File: rtl/sgpr_simxlsu_rd_port_arb.sv
// Round-robin arbitration of NUM_PORTS readers onto the single SGPR read port; accept-to-response RD_LAT+2.
// One accept per cycle, requesters wait on req_ready; responses have no backpressure.
module sgpr_simxlsu_rd_port_arb
  import sgpr_simxlsu_rd_port_arb_pkg::*;
#(
  parameter int NUM_PORTS = SGPR_RD_PORTS,
  parameter int ADDR_W    = SGPR_ADDR_W,
  parameter int DATA_W    = SGPR_DATA_W,
  parameter int RD_LAT    = SGPR_RD_LAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic                        sgpr_rd_en,
  output logic [ADDR_W-1:0]           sgpr_rd_addr,
  input  logic [DATA_W-1:0]           sgpr_rd_data,
  output logic [PORT_SEL_W-1:0]       rd_port_select,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data
);

  port_idx_t         rr_ptr;
  port_idx_t         next_ptr;
  port_idx_t         grant_idx;
  logic              grant_vld;
  logic [ADDR_W-1:0] grant_addr;
  owner_t            owner_q [RD_LAT+1];
  owner_t            ret_owner;

  sgpr_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (req_ready),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .next_ptr  (next_ptr)
  );

  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (req_ready[i]) grant_addr = req_addr[i*ADDR_W +: ADDR_W];
  end

  // Stage 0 lines up with sgpr_rd_en; the last stage is the cycle the bank data is valid.
  assign ret_owner = owner_q[RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr         <= '0;
      sgpr_rd_en     <= 1'b0;
      sgpr_rd_addr   <= '0;
      rd_port_select <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
      for (int s = 0; s <= RD_LAT; s++) owner_q[s] <= '0;
    end else begin
      sgpr_rd_en     <= grant_vld;
      rd_port_select <= grant_vld ? port_onehot(grant_idx) : '0;
      if (grant_vld) begin
        rr_ptr       <= next_ptr;
        sgpr_rd_addr <= grant_addr;
      end
      owner_q[0] <= '{vld: grant_vld, idx: grant_idx};
      for (int s = 1; s <= RD_LAT; s++) owner_q[s] <= owner_q[s-1];
      rsp_valid <= ret_owner.vld ? NUM_PORTS'(port_onehot(ret_owner.idx)) : '0;
      if (ret_owner.vld) rsp_data <= sgpr_rd_data;
    end
  end

endmodule

// File: tb/tb_sgpr_simxlsu_rd_port_arb.sv
// Bench: RD_LAT=1 and RD_LAT=3 builds share one request stream and are checked every cycle
// against a cycle-indexed schedule derived from the round-robin and latency rules.
module tb_sgpr_simxlsu_rd_port_arb;

  localparam int NP   = 10;
  localparam int AW   = 9;
  localparam int DW   = 128;
  localparam int NCYC = 2048;
  localparam logic [DW-1:0] JUNK = {4{32'hDEADBEEF}};
  localparam logic [DW-1:0] A5   = {16{8'hA5}};

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NP-1:0]   req_valid = '0;
  logic [NP*AW-1:0] req_addr = '0;

  logic [NP-1:0] ready1, ready3, rspv1, rspv3;
  logic          en1, en3;
  logic [AW-1:0] raddr1, raddr3;
  logic [15:0]   sel1, sel3;
  logic [DW-1:0] rdat1, rdat3, rspd1, rspd3;

  always #5 clk = ~clk;

  sgpr_simxlsu_rd_port_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(ready1),
    .sgpr_rd_en(en1), .sgpr_rd_addr(raddr1), .sgpr_rd_data(rdat1), .rd_port_select(sel1),
    .rsp_valid(rspv1), .rsp_data(rspd1));

  sgpr_simxlsu_rd_port_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(ready3),
    .sgpr_rd_en(en3), .sgpr_rd_addr(raddr3), .sgpr_rd_data(rdat3), .rd_port_select(sel3),
    .rsp_valid(rspv3), .rsp_data(rspd3));

  // SGPR bank models: data for the strobed address appears RD_LAT cycles later, junk otherwise.
  logic [DW-1:0] mem [512];
  logic          bk_v [2][3];
  logic [AW-1:0] bk_a [2][3];

  always @(posedge clk) begin
    bk_v[0][0] <= en1;
    bk_a[0][0] <= raddr1;
    bk_v[1][0] <= en3;
    bk_a[1][0] <= raddr3;
    for (int k = 1; k < 3; k++) begin
      bk_v[0][k] <= bk_v[0][k-1];
      bk_a[0][k] <= bk_a[0][k-1];
      bk_v[1][k] <= bk_v[1][k-1];
      bk_a[1][k] <= bk_a[1][k-1];
    end
  end

  assign rdat1 = bk_v[0][0] ? mem[bk_a[0][0]] : JUNK;
  assign rdat3 = bk_v[1][2] ? mem[bk_a[1][2]] : JUNK;

  int cyc = 0, ptr = 0, total = 0, passed = 0, fails = 0, last_acc = -1, rsp3_cnt = 0;
  int lat [2] = '{1, 3};
  logic [15:0]   sch_sel  [NCYC];
  logic [AW-1:0] sch_addr [NCYC];
  logic [NP-1:0] sch_rsp  [2][NCYC];
  logic [DW-1:0] sch_dat  [2][NCYC];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dat [2];
  logic [NP-1:0] dut_grant;
  logic [NP-1:0] grant_q [$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sched(input int from);
    for (int c = from; c < NCYC; c++) begin
      sch_sel[c]  = '0;
      sch_addr[c] = '0;
      for (int d = 0; d < 2; d++) begin
        sch_rsp[d][c] = '0;
        sch_dat[d][c] = '0;
      end
    end
  endtask

  // One clock: check both builds mid-cycle, then apply the accept rules to the schedule.
  task automatic tick();
    logic [NP-1:0] g;
    logic [AW-1:0] a;
    int j;
    @(negedge clk);
    if (!rst) begin
      clear_sched(cyc);
      ptr = 0;
      m_addr = '0;
      m_dat[0] = '0;
      m_dat[1] = '0;
    end
    g = '0;
    j = -1;
    for (int k = 0; k < NP; k++)
      if (j < 0 && req_valid[(ptr + k) % NP]) j = (ptr + k) % NP;
    if (j >= 0) g[j] = 1'b1;
    if (sch_sel[cyc] != '0) m_addr = sch_addr[cyc];
    for (int d = 0; d < 2; d++)
      if (sch_rsp[d][cyc] != '0) m_dat[d] = sch_dat[d][cyc];

    chk("ready1",    DW'(ready1), DW'(g));
    chk("ready3",    DW'(ready3), DW'(g));
    chk("rd_en1",    DW'(en1),    DW'(sch_sel[cyc] != '0));
    chk("rd_en3",    DW'(en3),    DW'(sch_sel[cyc] != '0));
    chk("rd_addr1",  DW'(raddr1), DW'(m_addr));
    chk("rd_addr3",  DW'(raddr3), DW'(m_addr));
    chk("port_sel1", DW'(sel1),   DW'(sch_sel[cyc]));
    chk("port_sel3", DW'(sel3),   DW'(sch_sel[cyc]));
    chk("rsp_vld1",  DW'(rspv1),  DW'(sch_rsp[0][cyc]));
    chk("rsp_vld3",  DW'(rspv3),  DW'(sch_rsp[1][cyc]));
    chk("rsp_dat1",  rspd1,       m_dat[0]);
    chk("rsp_dat3",  rspd3,       m_dat[1]);

    dut_grant = ready1;
    if (rspv3[2]) rsp3_cnt++;
    last_acc = -1;
    if (rst) grant_q.push_back(ready1);
    if (rst && j >= 0) begin
      a = AW'(req_addr >> (j * AW));
      ptr = (j + 1) % NP;
      sch_sel[cyc+1]  = 16'(1) << j;
      sch_addr[cyc+1] = a;
      for (int d = 0; d < 2; d++) begin
        sch_rsp[d][cyc+lat[d]+2] = NP'(1) << j;
        sch_dat[d][cyc+lat[d]+2] = mem[a];
      end
      last_acc = j;
    end
    cyc++;
    if (cyc + 8 >= NCYC) begin
      $display("FAIL cycle_budget: observed %0d cycles, limit %0d", cyc, NCYC - 8);
      $fatal(1, "cycle budget exhausted");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NP-1:0] e;
    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[9'h012] = A5;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) begin
        bk_v[d][k] = 1'b0;
        bk_a[d][k] = '0;
      end
    clear_sched(0);
    m_addr = '0;
    m_dat[0] = '0;
    m_dat[1] = '0;

    // Reset held with every port requesting: registered outputs stay 0.
    rst = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NP; i++) req_addr[i*AW +: AW] = AW'(i * 16 + 5);
    repeat (3) tick();
    rst = 1'b1;

    // Continuous all-port request from reset: grants 0..9 then 0 again.
    grant_q.delete();
    repeat (11) tick();
    for (int k = 0; k < 11; k++) begin
      e = '0;
      e[k % NP] = 1'b1;
      chk("all_req_order", DW'(grant_q[k]), DW'(e));
    end

    // Serve 1..9 so the pointer wraps, then 0 and 9 compete.
    repeat (9) tick();
    req_valid = 10'h201;
    tick();
    chk("wrap_port0_first", DW'(dut_grant), DW'(10'h001));
    req_valid = '0;
    repeat (8) tick();

    // Single read from port 3.
    req_valid = 10'h008;
    req_addr[3*AW +: AW] = 9'h012;
    tick();
    req_valid = '0;
    chk("single_rd_en",   DW'(en1),    DW'(1'b1));
    chk("single_rd_addr", DW'(raddr1), DW'(9'h012));
    chk("single_sel",     DW'(sel1),   DW'(16'h0008));
    repeat (2) tick();
    chk("single_rsp_vld", DW'(rspv1), DW'(10'h008));
    chk("single_rsp_dat", rspd1, A5);
    repeat (2) tick();
    chk("single_rsp_vld_lat3", DW'(rspv3), DW'(10'h008));
    chk("single_rsp_dat_lat3", rspd3, A5);
    repeat (4) tick();

    // Reset right after accepting port 5: the read is dropped and the pointer returns to 0.
    req_valid = 10'h020;
    req_addr[5*AW +: AW] = 9'h155;
    tick();
    req_valid = '0;
    rst = 1'b0;
    #1;
    chk("midrst_rd_en", DW'(en1), DW'(1'b0));
    chk("midrst_sel",   DW'(sel1), DW'(16'h0000));
    tick();
    rst = 1'b1;
    repeat (6) tick();
    req_valid = 10'h041;
    #1;
    chk("midrst_ptr0", DW'(ready1), DW'(10'h001));
    tick();
    req_valid = '0;
    repeat (8) tick();

    // Lone requester on port 2 for four cycles: accepted every cycle, four in-order responses.
    rsp3_cnt = 0;
    req_valid = 10'h004;
    for (int r = 0; r < 4; r++) begin
      req_addr[2*AW +: AW] = AW'($urandom);
      tick();
    end
    req_valid = '0;
    repeat (8) tick();
    chk("lone_rsp_count", DW'(rsp3_cnt), DW'(4));

    // Random requesters that hold valid/addr until accepted.
    for (int n = 0; n < 700; n++) begin
      for (int i = 0; i < NP; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'($urandom);
        end
      tick();
      if (last_acc >= 0) req_valid[last_acc] = 1'b0;
    end
    req_valid = '0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
